keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Parametrised ROWSxCOLS matrix-keypad scanner with built-in column sync, frame-based debounce,
//  multi-key detection and single-cycle key events. Drives one-hot rows, reads columns, emits a
//  linear key code. Sits between the keypad pins and the digit-memory/display path in the top level.
//  Replaces the separate fixed 4x4 scanner/debounce/synchronizer chain.
// PARAMETERS
//  ROWS            4     number of driven row lines (>=2)
//  COLS            4     number of sensed column lines (>=2)
//  SCAN_DIV        1000  clk cycles per row slot (>=2)
//  DEBOUNCE_SCANS  4     consecutive identical frames needed to accept a press or a release (>=1)
//  REPEAT_DELAY    16    frames held before the first auto-repeat (used only with TYPEMATIC_EN)
//  REPEAT_RATE     4     frames between auto-repeats (used only with TYPEMATIC_EN)
//  CODE_W          $clog2(ROWS*COLS)  localparam, key code width
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  cols_async  in   COLS    raw column inputs, active-high (pulled down), asynchronous
//  rows        out  ROWS    one-hot row drive, active-high
//  key_code    out  CODE_W  code of last accepted key = row*COLS + col; held until next event
//  key_valid   out  1       1-cycle pulse: key_code newly valid
//  key_held    out  1       level: accepted key still pressed
//  multi_key   out  1       level: last completed frame saw >1 pressed positions
// BEHAVIOUR
//  - Reset: rows=1 (row 0), key_code=0, key_valid=0, key_held=0, multi_key=0, divider=0, row idx=0,
//    FSM=IDLE, debounce count=0, sync flops=0. Reset mid-operation aborts any debounce; no pulse.
//  - cols_async passes a 2-flop synchronizer; only the synchronized value is used.
//  - Divider counts 0..SCAN_DIV-1; tick on SCAN_DIV-1. On tick: sample sync cols for current row,
//    then advance row idx (ROWS-1 wraps to 0); rows updates the next cycle.
//  - Frame = ROWS ticks; frame end = tick of row ROWS-1. Frame result: NONE (0 hits), SINGLE
//    (1 hit, code r*COLS+c), MULTI (>1 hits). multi_key updated at every frame end.
//  - FSM, evaluated at frame end only:
//    IDLE:    SINGLE -> DEBOUNCE, cand=code, cnt=1 (DEBOUNCE_SCANS=1: accept immediately -> HELD);
//             NONE/MULTI -> stay.
//    DEBOUNCE:SINGLE with code==cand -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> accept -> HELD.
//             SINGLE other code -> restart with new cand, cnt=1. NONE/MULTI -> IDLE, cnt=0.
//    HELD:    key_held=1. NONE -> RELEASE, cnt=1. SINGLE/MULTI -> stay (rollover ignored, no event).
//    RELEASE: NONE -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0. Any hit -> HELD, cnt=0.
//  - Accept: key_code<=cand and key_valid=1 for exactly the cycle after the frame-end tick.
//    Latency press->pulse: DEBOUNCE_SCANS frames (+ sync/alignment, < 1 extra frame + 3 cycles).
//  - key_held rises with the key_valid pulse; falls the cycle after release is accepted.
//  - Counters saturate; no wrap of cnt. Row idx and divider wrap as stated.
// CONFIGURATION
//  TYPEMATIC_EN defined: in HELD with the accepted key still SINGLE, a frame counter starts at
//    accept; first extra key_valid (same key_code) after REPEAT_DELAY frames, then every
//    REPEAT_RATE frames. NONE or MULTI frame pauses and resets the repeat counter.
//  TYPEMATIC_EN undefined: exactly one key_valid per press; repeat logic and parameters unused.
// TESTING  (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3; frame = 16 cycles)
//  1 reset held 5 cycles, cols=0 -> rows=4'b0001, key_valid/key_held/multi_key=0, key_code=0.
//  2 col1 high only while rows=4'b0100, stable -> one key_valid, key_code=9, within 4 frames; key_held=1.
//  3 same key toggling each frame (1 frame on, 1 off) for 20 frames -> key_valid never asserts.
//  4 keys 0 and 5 pressed together -> multi_key=1 after 1st full frame; no key_valid; release -> multi_key=0.
//  5 after test 2, cols=0 3 frames -> key_held=0; re-press code 9 -> second key_valid.
//  6 reset pulse after 2 matching frames in DEBOUNCE -> no key_valid, rows=4'b0001, re-debounce needs 3 frames.
//  7 TYPEMATIC_EN, REPEAT_DELAY=2, REPEAT_RATE=1, hold key 9 for 10 frames after accept -> 1+9 pulses.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if
//  Bundle of keypad pin and key-event signals between the matrix keypad scanner
//  and its consumer (digit memory / display path, or a testbench keypad model).
//  master : the scanner side (drives rows and key events, reads columns)
//  slave  : the keypad/consumer side (drives columns, reads rows and key events)
interface keypad_scan_ctrl_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = $clog2(ROWS * COLS)
) ();

  logic [COLS-1:0]   cols_async;
  logic [ROWS-1:0]   rows;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_key;

  modport master (
    input  cols_async,
    output rows,
    output key_code,
    output key_valid,
    output key_held,
    output multi_key
  );

  modport slave (
    output cols_async,
    input  rows,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  multi_key
  );

endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//  ROWS x COLS matrix keypad scanner: one-hot row drive, 2-flop column
//  synchronizer, frame-based debounce of press and release, multi-key flag and
//  single-cycle key events carrying a linear code (row*COLS + col).
//  Optional feature macro: TYPEMATIC_EN (auto-repeat while a key is held).
//  With TYPEMATIC_EN undefined exactly one key_valid is produced per press.
module keypad_scan_ctrl #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_RATE    = 4
) (
  input logic                clk,
  input logic                reset,
  keypad_scan_ctrl_if.master kp
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int RIDX_W = $clog2(ROWS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [RIDX_W-1:0] ROW_LAST = RIDX_W'(ROWS - 1);
  localparam logic [CNT_W-1:0]  DEB_N    = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ROWS-1:0]   ROW0_HOT = {{(ROWS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_t;

  // synchronizer and scan timing
  logic [COLS-1:0]   sync1_r;
  logic [COLS-1:0]   sync2_r;
  logic [DIV_W-1:0]  div_r;
  logic [RIDX_W-1:0] row_idx_r;
  logic [RIDX_W-1:0] row_next_s;
  logic [ROWS-1:0]   rows_r;
  logic              tick_s;
  logic              frame_end_s;

  // per-row and per-frame hit accumulation
  logic [1:0]        row_hits_s;
  logic [CODE_W-1:0] row_col_s;
  logic [1:0]        acc_hits_r;
  logic [CODE_W-1:0] acc_code_r;
  logic [2:0]        hit_sum_s;
  logic [1:0]        frame_hits_s;
  logic [CODE_W-1:0] frame_code_s;
  frame_t            frame_res_s;

  // debounce FSM
  state_t            state_r;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CODE_W-1:0] cand_r;
  logic [CODE_W-1:0] cand_n;
  logic              accept_s;
  logic              release_s;
  logic              repeat_s;

  // registered outputs
  logic [CODE_W-1:0] key_code_r;
  logic              key_valid_r;
  logic              key_held_r;
  logic              multi_key_r;

  assign tick_s      = (div_r == DIV_LAST);
  assign frame_end_s = tick_s && (row_idx_r == ROW_LAST);
  assign row_next_s  = (row_idx_r == ROW_LAST) ? {RIDX_W{1'b0}} : (row_idx_r + RIDX_W'(1));
  assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Two-flop synchronizer on the raw column inputs; nothing else reads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {COLS{1'b0}};
      sync2_r <= {COLS{1'b0}};
    end else begin
      sync1_r <= kp.cols_async;
      sync2_r <= sync1_r;
    end
  end

  // Row-slot divider; the tick marks the last cycle of each row slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Row index and one-hot row drive advance on the tick; rows follow one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx_r <= {RIDX_W{1'b0}};
      rows_r    <= ROW0_HOT;
    end else if (tick_s) begin
      row_idx_r <= row_next_s;
      rows_r    <= ROW0_HOT << row_next_s;
    end else begin
      row_idx_r <= row_idx_r;
      rows_r    <= rows_r;
    end
  end

  // Count pressed columns in the current row (saturating at 2) and locate the hit.
  always_comb begin
    row_hits_s = 2'd0;
    row_col_s  = {CODE_W{1'b0}};
    for (int c = 0; c < COLS; c++) begin
      if (sync2_r[c]) begin
        row_col_s = CODE_W'(c);
        if (row_hits_s != 2'd2) begin
          row_hits_s = row_hits_s + 2'd1;
        end else begin
          row_hits_s = row_hits_s;
        end
      end else begin
        row_col_s = row_col_s;
      end
    end
  end

  // Merge this row into the running frame result; the merged value is the frame result at frame end.
  always_comb begin
    hit_sum_s = {1'b0, acc_hits_r} + {1'b0, row_hits_s};
    if (hit_sum_s >= 3'd2) begin
      frame_hits_s = 2'd2;
    end else begin
      frame_hits_s = hit_sum_s[1:0];
    end
    if (row_hits_s == 2'd1) begin
      frame_code_s = (CODE_W'(row_idx_r) * CODE_W'(COLS)) + row_col_s;
    end else begin
      frame_code_s = acc_code_r;
    end
    case (frame_hits_s)
      2'd0:    frame_res_s = FR_NONE;
      2'd1:    frame_res_s = FR_SINGLE;
      default: frame_res_s = FR_MULTI;
    endcase
  end

  // Frame accumulators: updated on every tick, cleared at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hits_r <= 2'd0;
      acc_code_r <= {CODE_W{1'b0}};
    end else if (frame_end_s) begin
      acc_hits_r <= 2'd0;
      acc_code_r <= {CODE_W{1'b0}};
    end else if (tick_s) begin
      acc_hits_r <= frame_hits_s;
      acc_code_r <= frame_code_s;
    end else begin
      acc_hits_r <= acc_hits_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Debounce FSM state, frame counter and candidate code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      cand_r  <= {CODE_W{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      cand_r  <= cand_n;
    end
  end

  // Debounce FSM next state; only frame results move it, so it acts at frame end only.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    cand_n    = cand_r;
    accept_s  = 1'b0;
    release_s = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (frame_res_s == FR_SINGLE) begin
            cand_n = frame_code_s;
            if (CNT_ONE >= DEB_N) begin
              accept_s = 1'b1;
              state_n  = ST_HELD;
              cnt_n    = {CNT_W{1'b0}};
            end else begin
              state_n = ST_DEBOUNCE;
              cnt_n   = CNT_ONE;
            end
          end else begin
            state_n = ST_IDLE;
            cnt_n   = {CNT_W{1'b0}};
          end
        end
        ST_DEBOUNCE: begin
          if ((frame_res_s == FR_SINGLE) && (frame_code_s == cand_r)) begin
            if (cnt_inc_s >= DEB_N) begin
              accept_s = 1'b1;
              state_n  = ST_HELD;
              cnt_n    = {CNT_W{1'b0}};
            end else begin
              cnt_n = cnt_inc_s;
            end
          end else if (frame_res_s == FR_SINGLE) begin
            cand_n = frame_code_s;
            cnt_n  = CNT_ONE;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = {CNT_W{1'b0}};
          end
        end
        ST_HELD: begin
          if (frame_res_s == FR_NONE) begin
            if (CNT_ONE >= DEB_N) begin
              release_s = 1'b1;
              state_n   = ST_IDLE;
              cnt_n     = {CNT_W{1'b0}};
            end else begin
              state_n = ST_RELEASE;
              cnt_n   = CNT_ONE;
            end
          end else begin
            state_n = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (frame_res_s == FR_NONE) begin
            if (cnt_inc_s >= DEB_N) begin
              release_s = 1'b1;
              state_n   = ST_IDLE;
              cnt_n     = {CNT_W{1'b0}};
            end else begin
              cnt_n = cnt_inc_s;
            end
          end else begin
            state_n = ST_HELD;
            cnt_n   = {CNT_W{1'b0}};
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

`ifdef TYPEMATIC_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_N = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE_N  = REP_W'(REPEAT_RATE);
  localparam logic [REP_W-1:0] REP_MAXV    = {REP_W{1'b1}};

  logic [REP_W-1:0] rep_cnt_r;
  logic [REP_W-1:0] rep_cnt_n;
  logic [REP_W-1:0] rep_inc_s;
  logic             rep_first_r;
  logic             rep_first_n;

  assign rep_inc_s = (rep_cnt_r == REP_MAXV) ? rep_cnt_r : (rep_cnt_r + REP_W'(1));

  // Auto-repeat frame counter: runs while the accepted key alone stays pressed in HELD.
  always_comb begin
    rep_cnt_n   = rep_cnt_r;
    rep_first_n = rep_first_r;
    repeat_s    = 1'b0;
    if (accept_s) begin
      rep_cnt_n   = {REP_W{1'b0}};
      rep_first_n = 1'b0;
    end else if (frame_end_s) begin
      if ((state_r == ST_HELD) && (frame_res_s == FR_SINGLE) && (frame_code_s == key_code_r)) begin
        if (!rep_first_r && (rep_inc_s >= REP_DELAY_N)) begin
          repeat_s    = 1'b1;
          rep_cnt_n   = {REP_W{1'b0}};
          rep_first_n = 1'b1;
        end else if (rep_first_r && (rep_inc_s >= REP_RATE_N)) begin
          repeat_s  = 1'b1;
          rep_cnt_n = {REP_W{1'b0}};
        end else begin
          rep_cnt_n = rep_inc_s;
        end
      end else begin
        rep_cnt_n   = {REP_W{1'b0}};
        rep_first_n = 1'b0;
      end
    end else begin
      rep_cnt_n = rep_cnt_r;
    end
  end

  // Auto-repeat counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_n;
      rep_first_r <= rep_first_n;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
  assign repeat_s          = 1'b0;
`endif

  // Registered outputs: one-cycle event pulse, accepted code, held level, multi-key flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code_r  <= {CODE_W{1'b0}};
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      multi_key_r <= 1'b0;
    end else begin
      key_valid_r <= accept_s | repeat_s;
      if (accept_s) begin
        key_code_r <= cand_n;
        key_held_r <= 1'b1;
      end else if (release_s) begin
        key_code_r <= key_code_r;
        key_held_r <= 1'b0;
      end else begin
        key_code_r <= key_code_r;
        key_held_r <= key_held_r;
      end
      if (frame_end_s) begin
        multi_key_r <= (frame_res_s == FR_MULTI);
      end else begin
        multi_key_r <= multi_key_r;
      end
    end
  end

  assign kp.rows      = rows_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;
  assign kp.multi_key = multi_key_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
//  4x4 keypad, SCAN_DIV=4 (16-cycle frame), DEBOUNCE_SCANS=3, REPEAT_DELAY=2,
//  REPEAT_RATE=1. A behavioural keypad turns a pressed-key mask into column
//  levels from the driven rows. Each vector is applied at a frame boundary and
//  held for a whole number of frames; expected key events go into a queue and
//  are matched by a monitor against every key_valid pulse.
module tb_keypad_scan_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
  localparam int FRAME  = 16;
`ifdef TYPEMATIC_EN
  localparam int TM = 1;
`else
  localparam int TM = 0;
`endif

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          frames;
    int          pulses;
    int          kc;
    logic        held;
    logic        multi;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] keys;
  logic [3:0]  cols_m;
  int          n_vec;
  int          n_err;
  int          pulse_cnt;
  int          exp_q[$];
  vec_t        tbl[23];

  keypad_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row line to its column line.
  always_comb begin
    cols_m = 4'b0000;
    for (int r = 0; r < ROWS; r++) begin
      if (kp.rows[r]) cols_m = cols_m | keys[r*4 +: 4];
    end
  end
  assign kp.cols_async = cols_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] k, input int f,
                              input int p, input int kc, input logic h, input logic m);
    vec_t v;
    v.name = n; v.keys = k; v.frames = f; v.pulses = p; v.kc = kc; v.held = h; v.multi = m;
    return v;
  endfunction

  // Monitor: every key_valid pulse must be one cycle wide and match the queued code.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    pulse_cnt  = 0;
    forever begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin
        pulse_cnt++;
        check("pulse_width", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_pulse: key_valid with code %0d, no event expected", kp.key_code);
        end else begin
          check("pulse_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = kp.key_valid;
    end
  end

  // Wait for the row sequence to wrap so the next cycle starts a fresh frame.
  task automatic align();
    int n;
    n = 0;
    while (kp.rows !== 4'b1000 && n < 64) begin @(negedge clk); n++; end
    check("align_row3", 32'(kp.rows), 32'h8);
    n = 0;
    while (kp.rows !== 4'b0001 && n < 64) begin @(negedge clk); n++; end
    check("align_row0", 32'(kp.rows), 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    int p0;
    keys = v.keys;
    for (int i = 0; i < v.pulses; i++) exp_q.push_back(v.kc);
    p0 = pulse_cnt;
    repeat (FRAME * v.frames) @(negedge clk);
    #1;
    check({v.name, "_pulses"}, 32'(pulse_cnt - p0), 32'(v.pulses));
    check({v.name, "_code"},   32'(kp.key_code),    32'(v.kc));
    check({v.name, "_held"},   32'(kp.key_held),    32'(v.held));
    check({v.name, "_multi"},  32'(kp.multi_key),   32'(v.multi));
    exp_q.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    keys  = 16'h0000;

    tbl[0]  = mk("idle",        16'h0000, 2, 0,        0,  1'b0, 1'b0);
    tbl[1]  = mk("k9_deb2",     16'h0200, 2, 0,        0,  1'b0, 1'b0);
    tbl[2]  = mk("k9_accept",   16'h0200, 1, 1,        9,  1'b1, 1'b0);
    tbl[3]  = mk("k9_hold",     16'h0200, 4, TM * 3,   9,  1'b1, 1'b0);
    tbl[4]  = mk("k9_rel2",     16'h0000, 2, 0,        9,  1'b1, 1'b0);
    tbl[5]  = mk("k9_rel3",     16'h0000, 1, 0,        9,  1'b0, 1'b0);
    tbl[6]  = mk("k9_repress",  16'h0200, 3, 1,        9,  1'b1, 1'b0);
    tbl[7]  = mk("k9_release",  16'h0000, 3, 0,        9,  1'b0, 1'b0);
    tbl[8]  = mk("k0k5_multi",  16'h0021, 1, 0,        9,  1'b0, 1'b1);
    tbl[9]  = mk("k0k5_hold",   16'h0021, 3, 0,        9,  1'b0, 1'b1);
    tbl[10] = mk("multi_clear", 16'h0000, 1, 0,        9,  1'b0, 1'b0);
    tbl[11] = mk("row3_multi",  16'h3000, 1, 0,        9,  1'b0, 1'b1);
    tbl[12] = mk("k15_accept",  16'h8000, 3, 1,        15, 1'b1, 1'b0);
    tbl[13] = mk("rollover",    16'h8001, 2, 0,        15, 1'b1, 1'b1);
    tbl[14] = mk("k15_release", 16'h0000, 3, 0,        15, 1'b0, 1'b0);
    tbl[15] = mk("k3_cand",     16'h0008, 1, 0,        15, 1'b0, 1'b0);
    tbl[16] = mk("k4_restart",  16'h0010, 2, 0,        15, 1'b0, 1'b0);
    tbl[17] = mk("k4_accept",   16'h0010, 1, 1,        4,  1'b1, 1'b0);
    tbl[18] = mk("k4_release",  16'h0000, 3, 0,        4,  1'b0, 1'b0);
    tbl[19] = mk("k0_accept",   16'h0001, 3, 1,        0,  1'b1, 1'b0);
    tbl[20] = mk("k0_rel2",     16'h0000, 2, 0,        0,  1'b1, 1'b0);
    tbl[21] = mk("k0_bounce",   16'h0001, 1, 0,        0,  1'b1, 1'b0);
    tbl[22] = mk("k0_release",  16'h0000, 3, 0,        0,  1'b0, 1'b0);

    // Reset state with idle columns.
    repeat (5) @(negedge clk);
    check("rst_rows",  32'(kp.rows),      32'h1);
    check("rst_code",  32'(kp.key_code),  32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_held",  32'(kp.key_held),  32'h0);
    check("rst_multi", 32'(kp.multi_key), 32'h0);
    reset = 1'b0;
    align();

    for (int i = 0; i < 23; i++) run_vec(tbl[i]);

    // Key 9 chattering one frame on, one frame off: never accepted.
    for (int i = 0; i < 20; i++) begin
      run_vec(mk("toggle", (i % 2 == 0) ? 16'h0200 : 16'h0000, 1, 0, 0, 1'b0, 1'b0));
    end

    // Reset after two matching frames aborts the debounce without an event.
    run_vec(mk("pre_rst_deb2", 16'h0200, 2, 0, 0, 1'b0, 1'b0));
    keys  = 16'h0000;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rows",  32'(kp.rows),      32'h1);
    check("midrst_valid", 32'(kp.key_valid), 32'h0);
    check("midrst_held",  32'(kp.key_held),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    align();
    run_vec(mk("post_rst_deb2",   16'h0200, 2, 0, 0, 1'b0, 1'b0));
    run_vec(mk("post_rst_accept", 16'h0200, 1, 1, 9, 1'b1, 1'b0));
    run_vec(mk("post_rst_rel",    16'h0000, 3, 0, 9, 1'b0, 1'b0));

    // Long hold: auto-repeat every frame after a 2-frame delay when enabled.
    run_vec(mk("tm_accept",  16'h0200, 3,  1,      9, 1'b1, 1'b0));
    run_vec(mk("tm_hold10",  16'h0200, 10, TM * 9, 9, 1'b1, 1'b0));
    run_vec(mk("tm_release", 16'h0000, 3,  0,      9, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
